// File: rtl/mdu_unit.sv
// Multiply/divide unit with HI/LO registers: multi-cycle mult/div with a fixed busy window,
// plus direct HI/LO moves. The result is computed at accept time and committed when the window ends.
module mdu_unit #(
    parameter int unsigned MULT_CYC = 5,
    parameter int unsigned DIV_CYC  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  MDUOp,
    input  logic        start,
    input  logic        req,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        MDUing,
    output logic [31:0] MDU_out,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned CW = 4;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_busy;
    logic            r_keep;
    logic [31:0]     r_hi;
    logic [31:0]     r_lo;
    logic [31:0]     r_hi_res;
    logic [31:0]     r_lo_res;

    logic               w_accept;
    logic               w_md_op;
    logic signed [63:0] w_prod_s;
    logic [63:0]        w_prod_u;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [31:0]        w_a_mag;
    logic [31:0]        w_b_mag;
    logic [31:0]        w_dvd;
    logic [31:0]        w_dvs;
    logic [31:0]        w_q_mag;
    logic [31:0]        w_r_mag;
    logic [31:0]        w_q;
    logic [31:0]        w_r;

    assign w_accept = start & ~req & ~r_busy;
    assign w_md_op  = (MDUOp >= OP_MULT) && (MDUOp <= OP_DIVU);

    assign w_prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign w_prod_u = {32'd0, A} * {32'd0, B};

    // Signed division done on magnitudes so the most-negative / -1 case falls out without overflow.
    assign w_a_neg = (MDUOp == OP_DIV) & A[31];
    assign w_b_neg = (MDUOp == OP_DIV) & B[31];
    assign w_a_mag = A[31] ? (~A + 32'd1) : A;
    assign w_b_mag = B[31] ? (~B + 32'd1) : B;
    assign w_dvd   = (MDUOp == OP_DIV) ? w_a_mag : A;
    assign w_dvs   = (B == 32'd0) ? 32'd1 : ((MDUOp == OP_DIV) ? w_b_mag : B);
    assign w_q_mag = w_dvd / w_dvs;
    assign w_r_mag = w_dvd % w_dvs;
    assign w_q     = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 32'd1) : w_q_mag;
    assign w_r     = w_a_neg ? (~w_r_mag + 32'd1) : w_r_mag;

    // Sequencer: accept in IDLE, count down in RUN, commit held result on the last busy cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_keep   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_hi_res <= '0;
            r_lo_res <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        case (MDUOp)
                            OP_MULT: begin
                                r_hi_res <= w_prod_s[63:32];
                                r_lo_res <= w_prod_s[31:0];
                                r_keep   <= 1'b0;
                                r_cnt    <= CW'(MULT_CYC);
                                r_busy   <= 1'b1;
                                r_state  <= S_RUN;
                            end
                            OP_MULTU: begin
                                r_hi_res <= w_prod_u[63:32];
                                r_lo_res <= w_prod_u[31:0];
                                r_keep   <= 1'b0;
                                r_cnt    <= CW'(MULT_CYC);
                                r_busy   <= 1'b1;
                                r_state  <= S_RUN;
                            end
                            OP_DIV, OP_DIVU: begin
                                r_hi_res <= w_r;
                                r_lo_res <= w_q;
                                r_keep   <= (B == 32'd0);
                                r_cnt    <= CW'(DIV_CYC);
                                r_busy   <= 1'b1;
                                r_state  <= S_RUN;
                            end
                            OP_MTHI: r_hi <= A;
                            OP_MTLO: r_lo <= A;
                            default: ;
                        endcase
                    end
                end
                S_RUN: begin
                    if (r_cnt == CW'(1)) begin
                        if (!r_keep) begin
                            r_hi <= r_hi_res;
                            r_lo <= r_lo_res;
                        end
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign HI     = r_hi;
    assign LO     = r_lo;
    assign MDUing = r_busy | (start & w_md_op & ~req);

    always_comb begin
        MDU_out = 32'd0;
        case (MDUOp)
            OP_MFHI: MDU_out = r_hi;
            OP_MFLO: MDU_out = r_lo;
            default: MDU_out = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_mdu_unit.sv
// Directed bench for mdu_unit: busy window length, mult/div results, HI/LO moves,
// flush and busy-time op rejection, asynchronous reset mid-operation.
module tb_mdu_unit;

    logic        clk;
    logic        reset;
    logic [3:0]  MDUOp;
    logic        start;
    logic        req;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        MDUing;
    logic [31:0] MDU_out;
    logic [31:0] HI;
    logic [31:0] LO;

    int total = 0;
    int bad   = 0;

    mdu_unit #(.MULT_CYC(5), .DIV_CYC(10)) dut (
        .clk(clk), .reset(reset), .MDUOp(MDUOp), .start(start), .req(req),
        .A(A), .B(B), .busy(busy), .MDUing(MDUing), .MDU_out(MDU_out),
        .HI(HI), .LO(LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one op for exactly one rising edge, then clear the inputs.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        MDUOp = op; A = a; B = b; start = 1'b1; req = 1'b0;
        @(negedge clk);
        MDUOp = 4'd0; A = 32'd0; B = 32'd0; start = 1'b0;
    endtask

    // Count consecutive busy cycles from the current negedge, bounded.
    task automatic count_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 30) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        #12;
        MDUOp = 4'd5; #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (HI !== 32'd0) begin bad++; $display("FAIL reset_hi: got %h want 0", HI); end
        total++; if (LO !== 32'd0) begin bad++; $display("FAIL reset_lo: got %h want 0", LO); end
        total++; if (MDUing !== 1'b0) begin bad++; $display("FAIL reset_mduing: got %b want 0", MDUing); end
        total++; if (MDU_out !== 32'd0) begin bad++; $display("FAIL reset_mfhi: got %h want 0", MDU_out); end
        MDUOp = 4'd0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_mult();
        int n;
        @(negedge clk);
        MDUOp = 4'd1; A = 32'hFFFF_FFFE; B = 32'd3; start = 1'b1; req = 1'b0;
        #1;
        total++; if (MDUing !== 1'b1) begin bad++; $display("FAIL mult_mduing: got %b want 1", MDUing); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mult_busy_pre: got %b want 0", busy); end
        @(negedge clk);
        MDUOp = 4'd0; A = 32'd0; B = 32'd0; start = 1'b0;
        count_busy(n);
        total++; if (n !== 5) begin bad++; $display("FAIL mult_busy_len: got %0d want 5", n); end
        total++; if (HI !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mult_hi: got %h want ffffffff", HI); end
        total++; if (LO !== 32'hFFFF_FFFA) begin bad++; $display("FAIL mult_lo: got %h want fffffffa", LO); end
        MDUOp = 4'd5; #1;
        total++; if (MDU_out !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mfhi_read: got %h want ffffffff", MDU_out); end
        MDUOp = 4'd6; #1;
        total++; if (MDU_out !== 32'hFFFF_FFFA) begin bad++; $display("FAIL mflo_read: got %h want fffffffa", MDU_out); end
        MDUOp = 4'd9; #1;
        total++; if (MDU_out !== 32'd0) begin bad++; $display("FAIL other_op_out: got %h want 0", MDU_out); end
        MDUOp = 4'd0;
    endtask

    task automatic test_multu();
        int n;
        issue(4'd2, 32'hFFFF_FFFF, 32'd2);
        count_busy(n);
        total++; if (n !== 5) begin bad++; $display("FAIL multu_busy_len: got %0d want 5", n); end
        total++; if (HI !== 32'd1) begin bad++; $display("FAIL multu_hi: got %h want 1", HI); end
        total++; if (LO !== 32'hFFFF_FFFE) begin bad++; $display("FAIL multu_lo: got %h want fffffffe", LO); end
    endtask

    task automatic test_div();
        int n;
        issue(4'd3, 32'hFFFF_FFF9, 32'd2);
        count_busy(n);
        total++; if (n !== 10) begin bad++; $display("FAIL div_busy_len: got %0d want 10", n); end
        total++; if (LO !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_lo: got %h want fffffffd", LO); end
        total++; if (HI !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_hi: got %h want ffffffff", HI); end
        issue(4'd3, 32'd7, 32'hFFFF_FFFE);
        count_busy(n);
        total++; if (LO !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_negb_lo: got %h want fffffffd", LO); end
        total++; if (HI !== 32'd1) begin bad++; $display("FAIL div_negb_hi: got %h want 1", HI); end
        issue(4'd4, 32'hFFFF_FFFF, 32'h10);
        count_busy(n);
        total++; if (LO !== 32'h0FFF_FFFF) begin bad++; $display("FAIL divu_lo: got %h want 0fffffff", LO); end
        total++; if (HI !== 32'hF) begin bad++; $display("FAIL divu_hi: got %h want f", HI); end
        issue(4'd4, 32'd100, 32'd7);
        count_busy(n);
        total++; if (LO !== 32'd14 || HI !== 32'd2) begin bad++; $display("FAIL divu_small: got hi=%h lo=%h want hi=2 lo=e", HI, LO); end
        issue(4'd4, 32'd7, 32'd0);
        count_busy(n);
        total++; if (n !== 10) begin bad++; $display("FAIL divz_busy_len: got %0d want 10", n); end
        total++; if (LO !== 32'd14 || HI !== 32'd2) begin bad++; $display("FAIL divz_keep: got hi=%h lo=%h want hi=2 lo=e", HI, LO); end
        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        count_busy(n);
        total++; if (LO !== 32'h8000_0000) begin bad++; $display("FAIL div_ovf_lo: got %h want 80000000", LO); end
        total++; if (HI !== 32'd0) begin bad++; $display("FAIL div_ovf_hi: got %h want 0", HI); end
    endtask

    task automatic test_flush();
        @(negedge clk);
        MDUOp = 4'd1; A = 32'd5; B = 32'd5; start = 1'b1; req = 1'b1;
        #1;
        total++; if (MDUing !== 1'b0) begin bad++; $display("FAIL flush_mduing: got %b want 0", MDUing); end
        @(negedge clk);
        MDUOp = 4'd0; start = 1'b0; req = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_busy: got %b want 0", busy); end
        total++; if (LO !== 32'h8000_0000 || HI !== 32'd0) begin bad++; $display("FAIL flush_keep: got hi=%h lo=%h want hi=0 lo=80000000", HI, LO); end
        issue(4'd7, 32'h1234, 32'd0);
        total++; if (HI !== 32'h1234) begin bad++; $display("FAIL mthi: got %h want 1234", HI); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mthi_busy: got %b want 0", busy); end
        MDUOp = 4'd5; #1;
        total++; if (MDU_out !== 32'h1234) begin bad++; $display("FAIL mthi_mfhi: got %h want 1234", MDU_out); end
        issue(4'd8, 32'h5678, 32'd0);
        MDUOp = 4'd6; #1;
        total++; if (MDU_out !== 32'h5678) begin bad++; $display("FAIL mtlo_mflo: got %h want 5678", MDU_out); end
        @(negedge clk);
        MDUOp = 4'd7; A = 32'hAAAA; start = 1'b1; req = 1'b1;
        @(negedge clk);
        MDUOp = 4'd8; A = 32'hBBBB; start = 1'b0; req = 1'b0;
        @(negedge clk);
        MDUOp = 4'd0; A = 32'd0;
        total++; if (HI !== 32'h1234 || LO !== 32'h5678) begin bad++; $display("FAIL mt_ignored: got hi=%h lo=%h want hi=1234 lo=5678", HI, LO); end
    endtask

    task automatic test_busy_ignore();
        int n;
        @(negedge clk);
        MDUOp = 4'd1; A = 32'd3; B = 32'd4; start = 1'b1; req = 1'b0;
        n = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (busy !== 1'b1) break;
            n++;
            case (k)
                0: begin
                    MDUOp = 4'd1; A = 32'd5; B = 32'd5; start = 1'b1; req = 1'b0; #1;
                    total++; if (MDUing !== 1'b1) begin bad++; $display("FAIL busy_mduing: got %b want 1", MDUing); end
                end
                1: begin MDUOp = 4'd8; A = 32'hDEAD; start = 1'b1; req = 1'b1; end
                2: begin
                    MDUOp = 4'd5; A = 32'd0; B = 32'd0; start = 1'b0; req = 1'b0; #1;
                    total++; if (MDU_out !== 32'h1234) begin bad++; $display("FAIL busy_mfhi: got %h want 1234", MDU_out); end
                end
                3: MDUOp = 4'd0;
                default: ;
            endcase
        end
        total++; if (n !== 5) begin bad++; $display("FAIL busy_ign_len: got %0d want 5", n); end
        total++; if (HI !== 32'd0 || LO !== 32'hC) begin bad++; $display("FAIL busy_ign_res: got hi=%h lo=%h want hi=0 lo=c", HI, LO); end
    endtask

    task automatic test_back_to_back();
        int n;
        issue(4'd1, 32'd6, 32'd7);
        count_busy(n);
        total++; if (LO !== 32'd42 || HI !== 32'd0) begin bad++; $display("FAIL b2b_first: got hi=%h lo=%h want hi=0 lo=2a", HI, LO); end
        issue(4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        count_busy(n);
        total++; if (n !== 5) begin bad++; $display("FAIL b2b_busy_len: got %0d want 5", n); end
        total++; if (LO !== 32'd1 || HI !== 32'd0) begin bad++; $display("FAIL b2b_second: got hi=%h lo=%h want hi=0 lo=1", HI, LO); end
    endtask

    task automatic test_reset_mid_run();
        issue(4'd7, 32'h77, 32'd0);
        issue(4'd3, 32'd100, 32'd3);
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        total++; if (HI !== 32'd0 || LO !== 32'd0) begin bad++; $display("FAIL rst_mid_hilo: got hi=%h lo=%h want 0", HI, LO); end
        @(negedge clk);
        reset = 1'b1;
        repeat (15) @(negedge clk);
        total++; if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin bad++; $display("FAIL rst_no_late: got busy=%b hi=%h lo=%h want 0", busy, HI, LO); end
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1; MDUOp = 4'd7; A = 32'h99; start = 1'b1; req = 1'b0;
        @(negedge clk);
        MDUOp = 4'd0; A = 32'd0; start = 1'b0;
        total++; if (HI !== 32'h99) begin bad++; $display("FAIL rst_first_accept: got %h want 99", HI); end
    endtask

    initial begin
        reset = 1'b1; MDUOp = 4'd0; start = 1'b0; req = 1'b0; A = 32'd0; B = 32'd0;
        #2 reset = 1'b0;
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_flush();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mdu_unit.md
MDU_UNIT -- requirements
Module: mdu_unit

Interface
REQ-001 Param MULT_CYC, default 5: busy cycles for mult/multu.
REQ-002 Param DIV_CYC, default 10: busy cycles for div/divu.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 MDUOp  input  4  E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, others = none.
REQ-006 start  input  1  E-stage instruction valid; op acts only when high.
REQ-007 req  input  1  exception/interrupt flush of the E-stage instruction this cycle.
REQ-008 A  input  32  rs operand (forwarded).
REQ-009 B  input  32  rt operand (forwarded).
REQ-010 busy  output  1  registered; high while a mult/div is in flight.
REQ-011 MDUing  output  1  combinational; busy OR (start AND op in 1..4 AND !req); drives the hazard unit's MDU stall input.
REQ-012 MDU_out  output  32  combinational; HI when op=5, LO when op=6, else 0.
REQ-013 HI  output  32  registered HI.
REQ-014 LO  output  32  registered LO.

Function
REQ-015 An op is accepted only when start=1, req=0, busy=0; otherwise ignored with no state change.
REQ-016 States: IDLE (busy=0), RUN (busy=1); counter cnt, 4 bits.
REQ-017 IDLE->RUN on accepted op 1..4; result computed from A, B in that cycle and held in internal regs; cnt loaded MULT_CYC or DIV_CYC.
REQ-018 In RUN cnt decrements each edge; on the edge where cnt=1, HI/LO take the held result, busy->0, state->IDLE.
REQ-019 busy is high for exactly MULT_CYC (DIV_CYC) consecutive cycles, starting the cycle after acceptance; HI/LO readable from the first cycle busy=0.
REQ-020 mult: {HI,LO} = signed 64-bit A*B; multu: unsigned 64-bit product.
REQ-021 div: LO = A/B truncated toward zero, HI = remainder with dividend's sign; divu: unsigned quotient/remainder.
REQ-022 div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
REQ-023 Division by zero: operation still runs DIV_CYC busy cycles; HI and LO left unchanged.
REQ-024 mthi (7)/mtlo (8) accepted per REQ-015: HI (LO) <= A at that edge; no busy.
REQ-025 mfhi/mflo (5/6) have no state effect; MDU_out reads current HI/LO regardless of busy.
REQ-026 req during RUN does not abort the in-flight operation.
REQ-027 Any op presented while busy=1 is ignored (hazard unit stalls it; block tolerates it).
REQ-028 Only one of HI/LO/state update paths is active per edge; RUN completion and a new accept cannot coincide.

Reset
REQ-029 reset=0 asynchronously forces busy=0, IDLE, cnt=0, HI=0, LO=0, held result=0, independent of clk.
REQ-030 Reset asserted mid-RUN discards the operation; HI/LO stay 0 after release.
REQ-031 First accept possible on the first rising edge with reset=1.

Verification
REQ-032 mult A=0xFFFFFFFE(-2), B=3, start=1 -> MDUing=1 same cycle; busy=1 for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-033 multu A=0xFFFFFFFF, B=2 -> after 5 busy cycles HI=1, LO=0xFFFFFFFE.
REQ-034 div A=-7 (0xFFFFFFF9), B=2 -> busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu A=7, B=0 -> busy 10 cycles, HI/LO unchanged.
REQ-035 mult with req=1 -> MDUing=0, busy stays 0, HI/LO unchanged; mthi A=0x1234 with req=0 -> HI=0x1234 next edge, mfhi MDU_out=0x1234.
REQ-036 div started, reset pulsed low at busy cycle 4 between clock edges -> busy=0, HI=LO=0 immediately; no late HI/LO write after release.
REQ-037 mult in RUN, second mult and mtlo presented during busy -> both ignored; only first result lands; busy drops exactly 5 cycles after acceptance.
